// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 controller slice.
// Holds the CP0 register addresses, the ExcCode values, the Status/Cause bit
// positions, the writable-bit masks and the two exception vector addresses.
package cp0_pkg;

    // CP0 register numbers (rd field of mtc0/mfc0, select 0)
    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;
    localparam logic [4:0] ADDR_CONFIG   = 5'd16;

    typedef enum logic [4:0] {
        ExcInt  = 5'd0,
        ExcAdEL = 5'd4,
        ExcAdES = 5'd5,
        ExcSys  = 5'd8,
        ExcBp   = 5'd9,
        ExcRI   = 5'd10,
        ExcOv   = 5'd12,
        ExcTr   = 5'd13
    } exc_code_e;

    // Status bit positions
    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_IM_HI = 15;
    localparam int unsigned STATUS_BEV   = 22;

    // Cause bit positions
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_IP_LO  = 8;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_TI     = 30;
    localparam int unsigned CAUSE_BD     = 31;

    // IM[15:8], EXL, IE and BEV are the only Status bits that hold state
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;

    localparam logic [31:0] VEC_BEV  = 32'hBFC0_0380;
    localparam logic [31:0] VEC_NORM = 32'h8000_0180;

    // Address-error exceptions are the only ones that capture BadVAddr
    function automatic logic is_addr_exc(logic [4:0] code);
        return (code == ExcAdEL) || (code == ExcAdES);
    endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: pipeline <-> CP0 bus.
// Carries the mtc0 write (we/waddr/wdata), the mfc0 read (raddr/rdata) and
// the exception-commit port (exc_valid/exc_code/exc_pc/exc_bd/exc_badvaddr,
// eret). master = pipeline / exception arbiter side, slave = CP0 side.
interface cp0_ctrl_if;
    import cp0_pkg::*;

    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret;

    modport master (
        output we, waddr, wdata, raddr,
        output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
        input  rdata
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
        output rdata
    );

endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with a Count prescaler.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   count_we    load Count from wdata, restart the prescaler
//   compare_we  load Compare from wdata, clear TI
//   wdata       write data
//   count       current Count
//   compare     current Compare
//   ti          timer interrupt pending
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    import cp0_pkg::*;

    logic [3:0]  presc_q, presc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        wrap;

    assign wrap = (presc_q == 4'(COUNT_DIV - 1));

    always_comb begin
        presc_d   = wrap ? 4'd0 : presc_q + 4'd1;
        count_d   = wrap ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        // A Count load replaces this cycle's increment entirely
        if (count_we) begin
            count_d = wdata;
            presc_d = 4'd0;
        end

        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
        // Compare write acknowledges the timer even if still equal
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= 4'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS32 Coprocessor-0 controller.
// Holds Status, Cause, EPC, BadVAddr (timer registers live in cp0_timer),
// applies exception/eret/mtc0 with priority exc_valid > eret > mtc0 and
// serves mfc0 reads combinationally.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus          cp0_ctrl_if.slave: mtc0 / mfc0 / exception commit / eret
//   hw_int       level-sensitive hardware interrupt lines
//   int_req      interrupt request to the exception arbiter
//   epc_o, status_o, cause_o  live register values
//   exc_vector   general exception vector selected by Status.BEV
module cp0_ctrl #(
    parameter int unsigned NUM_HW_INT = 6,
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic                  clk,
    input  logic                  rst,
    cp0_ctrl_if.slave             bus,
    input  logic [NUM_HW_INT-1:0] hw_int,
    output logic                  int_req,
    output logic [31:0]           epc_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           exc_vector
);
    import cp0_pkg::*;

    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  hw_q;
    logic [5:0]  hw_pad;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        wr_en;
    logic [31:0] cause;
    logic [7:0]  ip;

    // Unmapped lines stay zero so their IP bits read 0
    assign hw_pad = 6'(hw_int);

    // mtc0 only lands when neither exception nor eret commits this cycle
    assign wr_en = bus.we & ~bus.exc_valid & ~bus.eret;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_en && (bus.waddr == ADDR_COUNT)),
        .compare_we (wr_en && (bus.waddr == ADDR_COMPARE)),
        .wdata      (bus.wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;

        if (bus.exc_valid) begin
            // EPC/BD are frozen while already inside a handler
            if (!status_q[STATUS_EXL]) begin
                epc_d = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
                bd_d  = bus.exc_bd;
            end
            status_d[STATUS_EXL] = 1'b1;
            exccode_d            = bus.exc_code;
            if (is_addr_exc(bus.exc_code)) begin
                badvaddr_d = bus.exc_badvaddr;
            end
        end else if (bus.eret) begin
            status_d[STATUS_EXL] = 1'b0;
        end else if (bus.we) begin
            case (bus.waddr)
                ADDR_STATUS: status_d = bus.wdata & STATUS_WMASK;
                ADDR_CAUSE:  ip_sw_d  = bus.wdata[9:8];
                ADDR_EPC:    epc_d    = bus.wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            bd_q       <= 1'b0;
            exccode_q  <= 5'd0;
            ip_sw_q    <= 2'd0;
            hw_q       <= 6'd0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            hw_q       <= hw_pad;
        end
    end

    // IP7 is shared between the timer and the sixth hardware line
    assign ip = {ti | hw_q[5], hw_q[4:0], ip_sw_q};

    assign cause = {bd_q, ti, 14'd0, ip, 1'b0, exccode_q, 2'b00};

    assign int_req = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                     (|(ip & status_q[STATUS_IM_HI:STATUS_IM_LO]));

    assign epc_o      = epc_q;
    assign status_o   = status_q;
    assign cause_o    = cause;
    assign exc_vector = status_q[STATUS_BEV] ? VEC_BEV : VEC_NORM;

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.raddr)
            ADDR_BADVADDR: bus.rdata = badvaddr_q;
            ADDR_COUNT:    bus.rdata = count;
            ADDR_COMPARE:  bus.rdata = compare;
            ADDR_STATUS:   bus.rdata = status_q;
            ADDR_CAUSE:    bus.rdata = cause;
            ADDR_EPC:      bus.rdata = epc_q;
            ADDR_PRID:     bus.rdata = PRID_VAL;
            ADDR_CONFIG:   bus.rdata = CONFIG_VAL;
            default:       bus.rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed plan with literal expectations, then randomized
// traffic, all continuously compared against a field-level CP0 model.
`timescale 1ns/1ps
module tb_cp0_ctrl;
    localparam int unsigned NHW  = 6;
    localparam int unsigned CDIV = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NHW-1:0] hw_int = '0;
    logic           int_req;
    logic [31:0]    epc_o, status_o, cause_o, exc_vector;

    int checks   = 0;
    int failures = 0;

    cp0_ctrl_if bus ();

    cp0_ctrl #(
        .NUM_HW_INT (NHW),
        .COUNT_DIV  (CDIV),
        .PRID_VAL   (32'h004C_0102),
        .CONFIG_VAL (32'h0000_8000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hw_int     (hw_int),
        .int_req    (int_req),
        .epc_o      (epc_o),
        .status_o   (status_o),
        .cause_o    (cause_o),
        .exc_vector (exc_vector)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (register fields) ----------------
    bit          m_ok = 0;
    logic [31:0] m_count, m_compare, m_epc, m_bva;
    int          m_ticks;
    logic        m_ti, m_exl, m_ie, m_bev, m_bd;
    logic [7:0]  m_im;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;
    logic [4:0]  m_exc;
    bit          m_wr;

    function automatic logic [7:0] m_ip();
        return {m_ti | m_hw[5], m_hw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_status();
        return (32'(m_bev) << 22) | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
    endfunction

    function automatic logic m_int();
        return m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bva;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return 32'h004C_0102;
            5'd16:   return 32'h0000_8000;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_count = 0; m_compare = 0; m_ticks = 0; m_ti = 0;
            m_im = 0; m_exl = 0; m_ie = 0; m_bev = 1; m_ipsw = 0; m_hw = 0;
            m_bd = 0; m_exc = 0; m_epc = 0; m_bva = 0;
            m_ok = 1;
        end else begin
            m_wr = bus.we && !bus.exc_valid && !bus.eret;
            // TI uses the values that were live during this cycle
            if (m_wr && bus.waddr == 5'd11) m_ti = 0;
            else if (m_count == m_compare) m_ti = 1;
            if (m_wr && bus.waddr == 5'd9) begin
                m_count = bus.wdata;
                m_ticks = 0;
            end else begin
                m_ticks++;
                if (m_ticks == int'(CDIV)) begin
                    m_ticks = 0;
                    m_count = m_count + 1;
                end
            end
            if (m_wr && bus.waddr == 5'd11) m_compare = bus.wdata;
            m_hw = 6'(hw_int);
            if (bus.exc_valid) begin
                if (!m_exl) begin
                    m_epc = bus.exc_bd ? bus.exc_pc - 4 : bus.exc_pc;
                    m_bd  = bus.exc_bd;
                end
                m_exl = 1;
                m_exc = bus.exc_code;
                if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) m_bva = bus.exc_badvaddr;
            end else if (bus.eret) begin
                m_exl = 0;
            end else if (bus.we) begin
                if (bus.waddr == 5'd12) begin
                    m_im = bus.wdata[15:8]; m_exl = bus.wdata[1];
                    m_ie = bus.wdata[0];    m_bev = bus.wdata[22];
                end else if (bus.waddr == 5'd13) begin
                    m_ipsw = bus.wdata[9:8];
                end else if (bus.waddr == 5'd14) begin
                    m_epc = bus.wdata;
                end
            end
        end
    end

    // Compare DUT against the model mid-cycle
    always @(negedge clk) begin
        if (m_ok) begin
            check("rdata", bus.rdata, m_read(bus.raddr));
            check("int_req", 32'(int_req), 32'(m_int()));
            check("epc_o", epc_o, m_epc);
            check("status_o", status_o, m_status());
            check("cause_o", cause_o, m_cause());
            check("exc_vector", exc_vector, m_bev ? 32'hBFC0_0380 : 32'h8000_0180);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.we = 0; bus.exc_valid = 0; bus.eret = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1; bus.waddr = a; bus.wdata = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.raddr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic commit(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                          input logic [31:0] bva);
        bus.exc_valid = 1; bus.exc_code = code; bus.exc_pc = pc;
        bus.exc_bd = bd; bus.exc_badvaddr = bva;
        step();
        idle();
    endtask

    logic [4:0]  ra_tab [10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd31};
    logic [31:0] rv_tab [10] = '{32'h0, 32'h0, 32'h0, 32'h0040_0000, 32'h0, 32'h0,
                                 32'h004C_0102, 32'h0000_8000, 32'h0, 32'h0};
    logic [4:0]  code_tab [8] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13};
    logic [4:0]  addr_tab [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};

    initial begin
        logic [31:0] v;
        idle();
        bus.raddr = 0; bus.waddr = 0; bus.wdata = 0;
        bus.exc_code = 0; bus.exc_pc = 0; bus.exc_bd = 0; bus.exc_badvaddr = 0;

        // Reset values, read while reset is still held
        repeat (3) step();
        for (int i = 0; i < 10; i++) begin
            rd(ra_tab[i], v);
            check($sformatf("reset_read_%0d", ra_tab[i]), v, rv_tab[i]);
        end
        check("reset_int_req", 32'(int_req), 32'd0);
        check("reset_vector", exc_vector, 32'hBFC0_0380);
        rst = 0;

        // Timer: Count 0 -> 5 in 10 cycles, TI one cycle later
        wr(5'd12, 32'h0000_8001);
        check("vector_bev0", exc_vector, 32'h8000_0180);
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        repeat (10) step();
        rd(5'd9, v);
        check("count_at_10", v, 32'd5);
        check("int_before_ti", 32'(int_req), 32'd0);
        step();
        check("int_on_ti", 32'(int_req), 32'd1);
        check("cause_ti", 32'(cause_o[30]), 32'd1);
        wr(5'd11, 32'h0000_1000);
        check("int_after_cmp_wr", 32'(int_req), 32'd0);

        // Hardware interrupt and exception commit in a delay slot
        wr(5'd12, 32'h0000_0401);
        hw_int[0] = 1;
        check("hw_int_not_yet", 32'(int_req), 32'd0);
        step();
        check("hw_int_req", 32'(int_req), 32'd1);
        commit(5'd0, 32'h0040_0010, 1'b1, 32'd0);
        check("epc_bd", epc_o, 32'h0040_000C);
        check("cause_bd", 32'(cause_o[31]), 32'd1);
        check("exl_set", 32'(status_o[1]), 32'd1);
        check("int_masked_exl", 32'(int_req), 32'd0);
        bus.eret = 1; step(); idle();
        check("int_after_eret", 32'(int_req), 32'd1);

        // Nested exception: EPC/BD frozen, ExcCode and BadVAddr updated
        commit(5'd0, 32'h0040_0200, 1'b0, 32'd0);
        check("epc_first", epc_o, 32'h0040_0200);
        commit(5'd4, 32'h0040_0100, 1'b1, 32'h0000_0003);
        check("epc_frozen", epc_o, 32'h0040_0200);
        check("bd_frozen", 32'(cause_o[31]), 32'd0);
        check("exccode_4", 32'(cause_o[6:2]), 32'd4);
        rd(5'd8, v);
        check("badvaddr", v, 32'h0000_0003);

        // Priority: exception beats eret and mtc0 Status=0
        bus.eret = 1; step(); idle();
        bus.exc_valid = 1; bus.exc_code = 5'd8; bus.exc_pc = 32'h0040_0300; bus.exc_bd = 0;
        bus.eret = 1; bus.we = 1; bus.waddr = 5'd12; bus.wdata = 32'd0;
        step(); idle();
        check("prio_status", status_o, 32'h0000_0403);

        // Count write restarts the prescaler
        step();
        wr(5'd9, 32'h0000_0100);
        rd(5'd9, v); check("count_wr", v, 32'h0000_0100);
        step(); rd(5'd9, v); check("count_hold", v, 32'h0000_0100);
        step(); rd(5'd9, v); check("count_inc", v, 32'h0000_0101);

        // Software interrupt through Cause.IP[1:0]
        hw_int = '0;
        bus.eret = 1; step(); idle();
        wr(5'd13, 32'hFFFF_FFFF);
        check("cause_ipsw", cause_o & 32'h0000_03FC, 32'h0000_0320);
        check("int_sw_masked", 32'(int_req), 32'd0);
        wr(5'd12, 32'h0000_0301);
        check("int_sw", 32'(int_req), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            bus.raddr = addr_tab[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) hw_int = NHW'($urandom);
            if ($urandom_range(0, 99) < 30) begin
                bus.we    = 1;
                bus.waddr = addr_tab[$urandom_range(0, 8)];
                bus.wdata = $urandom;
                if (bus.waddr == 5'd11) bus.wdata = m_count + $urandom_range(0, 12);
                if (bus.waddr == 5'd9 && $urandom_range(0, 3) == 0) bus.wdata = 32'hFFFF_FFF8;
                if (bus.waddr == 5'd12 && $urandom_range(0, 1) == 0)
                    bus.wdata = bus.wdata & 32'hFFFF_FFFD;
            end
            if ($urandom_range(0, 99) < 6) begin
                bus.exc_valid    = 1;
                bus.exc_code     = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                                               : code_tab[$urandom_range(0, 7)];
                bus.exc_pc       = $urandom;
                bus.exc_bd       = 1'($urandom);
                bus.exc_badvaddr = $urandom;
            end
            if ($urandom_range(0, 99) < 8) bus.eret = 1;
            step();
        end
        idle();
        rst = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
